input_router_vc: RTL and testbench
==================================

# input_router_vc

Parametrised, pipelined successor to the per-input-port route computation stage of the NoC router. It accepts flits from one input port and computes an XY or YX dimension-ordered route on head flits. The route is held in a per-virtual-channel routing table so body and tail flits of the same packet follow it. Each flit leaves one cycle later with a one-hot output-port request, under a valid/ready handshake toward the VC buffers and arbiter.

## Interface
- FLIT_WIDTH, 34: total flit width; bits [FLIT_WIDTH-1:FLIT_WIDTH-2] carry the flit type.
- NUM_VC, 3: virtual channels; VC id in flit bits [VC_W-1:0], where VC_W = max(1, $clog2(NUM_VC)).
- X_W, 2: width of X destination, in the bits directly above the VC id.
- Y_W, 2: width of Y destination, in the bits directly above X.
- ROUTE_YX, 0: 0 selects XY routing (X resolved first); 1 selects YX.

- clk  in  1  clock, all state on rising edge.
- arst  in  1  asynchronous, active-low reset.
- router_x_i  in  X_W  this router's X coordinate, quasi-static.
- router_y_i  in  Y_W  this router's Y coordinate, quasi-static.
- flit_i  in  FLIT_WIDTH  input flit.
- flit_valid_i  in  1  flit_i valid.
- flit_ready_o  out  1  stage can accept a flit.
- flit_o  out  FLIT_WIDTH  registered flit.
- flit_valid_o  out  1  flit_o valid.
- flit_ready_i  in  1  downstream accepts flit_o.
- route_o  out  5  one-hot port request: [0] local, [1] north, [2] south, [3] west, [4] east.
- vc_o  out  VC_W  VC id of flit_o.
- route_err_o  out  1  protocol-error flag, qualified with flit_valid_o.

## Operation
- Flit types: 2'b00 head, 2'b01 body, 2'b10 tail, 2'b11 head_tail.
- Transfer in: flit_valid_i && flit_ready_o. Transfer out: flit_valid_o && flit_ready_i.
- Per-VC routing table holds one 5-bit route and one active bit per entry.
- XY route:
  - dest_x > router_x → east; dest_x < router_x → west.
  - Otherwise dest_y > router_y → south; dest_y < router_y → north.
  - Otherwise local.
  - Compare unsigned. Y increases southward.
- YX route: same rules, with the Y comparison checked before the X comparison.
- On transfer in, by type:
  - head: compute route; write it to table[vc]; set active.
  - head_tail: compute route; table unchanged.
  - body: use table[vc].
  - tail: use table[vc]; clear active.
- Errors (route_err_o = 1 on that output flit):
  - Head arriving while table[vc].active: new route overwrites the table entry.
  - Body or tail arriving while !table[vc].active: route_o = 5'b0. For a tail, active stays 0.
  - VC id ≥ NUM_VC: route_o = 5'b0 and table unchanged.
- Only accepted flits update the table. Stalled flits have no side effects.
- Table write and output capture happen in the same cycle. A back-to-back head then body on the same VC returns the new route to the body.

## Timing
- Latency: exactly 1 cycle from transfer in to flit_valid_o, when not stalled.
- flit_ready_o = !flit_valid_o || flit_ready_i. This is combinational from flit_ready_i; full throughput is one flit per cycle.
- While flit_valid_o && !flit_ready_i, flit_o, route_o, vc_o and route_err_o hold stable.
- Reset, asynchronous on arst low:
  - flit_valid_o = 0, flit_o = 0, route_o = 0, vc_o = 0, route_err_o = 0.
  - All table entries cleared: active = 0, route = 0.
- Reset asserted mid-packet discards in-flight state. The next body flit after reset is an error.
- route_o is one-hot or zero; never multi-hot.

## Structure
- Package noc_router_pkg holds:
  - flit type enum.
  - port index constants PORT_LOCAL, PORT_NORTH, PORT_SOUTH, PORT_WEST, PORT_EAST.
  - route_t (5-bit one-hot).
  - field-extraction helper functions for type, vc, x and y.
- Sub-module route_calc: combinational XY/YX computation.
  - Parameters X_W, Y_W, ROUTE_YX.
  - Inputs: destination and router coordinates. Output: route_t.
- Top level holds the routing table, the output register and the error logic.

## Test plan
- Router (1,1), XY:
  - head vc0 to (2,0) → route_o = 5'b10000 (east), error 0.
  - body vc0 → 5'b10000.
  - tail vc0 → 5'b10000; table[0].active then 0.
- Router (1,1), YX mode: head_tail to (2,0) → 5'b00010 (north). Then a body on vc0 → route_o = 0, route_err_o = 1.
- Interleaving:
  - head vc0 to (0,1) → west 5'b01000.
  - head vc1 to (1,1) → local 5'b00001.
  - alternating body flits on vc0 and vc1 keep 5'b01000 and 5'b00001 respectively.
- Backpressure: hold flit_ready_i = 0 for 3 cycles with an input flit pending.
  - flit_ready_o = 0; outputs stable.
  - No table change until the cycle the input is accepted.
  - Throughput returns to 1 flit/cycle on release.
- Head on an active VC:
  - head vc2 to (3,1) → east; second head vc2 to (1,3) → south 5'b00100 with route_err_o = 1.
  - Following body flit uses south.
- Reset: assert arst low mid-packet on vc0. All outputs go to 0 immediately. After release, a body on vc0 → route_o = 0, route_err_o = 1.

Source files
------------

// File: rtl/noc_router_pkg.sv
// noc_router_pkg: flit types, output-port indices and flit field helpers shared by the router input stage
package noc_router_pkg;
  typedef enum logic [1:0] {
    FT_HEAD      = 2'b00,
    FT_BODY      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;
  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_SOUTH = 2;
  localparam int PORT_WEST  = 3;
  localparam int PORT_EAST  = 4;
  localparam int NUM_PORTS  = 5;
  localparam int MAX_FLIT_W = 64;
  typedef logic [NUM_PORTS-1:0] route_t;
  function automatic route_t port_onehot(input int p);
    return route_t'(1 << p);
  endfunction
  function automatic flit_type_e get_type(input logic [MAX_FLIT_W-1:0] f, input int fw);
    return flit_type_e'(f[fw-1 -: 2]);
  endfunction
  function automatic logic [15:0] get_vc(input logic [MAX_FLIT_W-1:0] f, input int vc_w);
    return 16'(f & ((64'd1 << vc_w) - 64'd1));
  endfunction
  function automatic logic [15:0] get_x(input logic [MAX_FLIT_W-1:0] f, input int vc_w, input int x_w);
    return get_vc(f >> vc_w, x_w);
  endfunction
  function automatic logic [15:0] get_y(input logic [MAX_FLIT_W-1:0] f, input int vc_w, input int x_w,
                                        input int y_w);
    return get_vc(f >> (vc_w + x_w), y_w);
  endfunction
endpackage

// File: rtl/route_calc.sv
// route_calc: combinational dimension-ordered (XY or YX) output-port selection
// Ports: dest_x/dest_y destination, router_x/router_y this router, route one-hot port request.
module route_calc
  import noc_router_pkg::*;
#(
  parameter int X_W      = 2,
  parameter int Y_W      = 2,
  parameter bit ROUTE_YX = 1'b0
) (
  input  logic [X_W-1:0] dest_x,
  input  logic [Y_W-1:0] dest_y,
  input  logic [X_W-1:0] router_x,
  input  logic [Y_W-1:0] router_y,
  output route_t         route
);
  route_t x_hop, y_hop, first, second;
  assign x_hop  = (dest_x > router_x) ? port_onehot(PORT_EAST) :
                  (dest_x < router_x) ? port_onehot(PORT_WEST) : '0;
  assign y_hop  = (dest_y > router_y) ? port_onehot(PORT_SOUTH) :
                  (dest_y < router_y) ? port_onehot(PORT_NORTH) : '0;
  assign first  = ROUTE_YX ? y_hop : x_hop;
  assign second = ROUTE_YX ? x_hop : y_hop;
  assign route  = (|first) ? first : (|second) ? second : port_onehot(PORT_LOCAL);
endmodule

// File: rtl/input_router_vc.sv
// input_router_vc: per-input-port route computation stage with per-VC routing table and 1-cycle output register
// Ports: clk, arst (async active-low); router_x_i/router_y_i coordinates; flit_i/flit_valid_i/flit_ready_o in;
// flit_o/flit_valid_o/flit_ready_i out; route_o one-hot port request; vc_o; route_err_o protocol error.
module input_router_vc
  import noc_router_pkg::*;
#(
  parameter int FLIT_WIDTH = 34,
  parameter int NUM_VC     = 3,
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter bit ROUTE_YX   = 1'b0,
  localparam int VC_W      = ($clog2(NUM_VC) > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [X_W-1:0]        router_x_i,
  input  logic [Y_W-1:0]        router_y_i,
  input  logic [FLIT_WIDTH-1:0] flit_i,
  input  logic                  flit_valid_i,
  output logic                  flit_ready_o,
  output logic [FLIT_WIDTH-1:0] flit_o,
  output logic                  flit_valid_o,
  input  logic                  flit_ready_i,
  output route_t                route_o,
  output logic [VC_W-1:0]       vc_o,
  output logic                  route_err_o
);
  logic [MAX_FLIT_W-1:0] f_ext;
  flit_type_e ftype;
  logic [VC_W-1:0] vc;
  logic [X_W-1:0] dest_x;
  logic [Y_W-1:0] dest_y;
  route_t calc_route, cur_route, nxt_route;
  route_t tbl_route [NUM_VC];
  logic [NUM_VC-1:0] tbl_active;
  logic cur_active, vc_ok, is_new, nxt_err, accept;
  assign f_ext  = MAX_FLIT_W'(flit_i);
  assign ftype  = get_type(f_ext, FLIT_WIDTH);
  assign vc     = VC_W'(get_vc(f_ext, VC_W));
  assign dest_x = X_W'(get_x(f_ext, VC_W, X_W));
  assign dest_y = Y_W'(get_y(f_ext, VC_W, X_W, Y_W));
  route_calc #(.X_W(X_W), .Y_W(Y_W), .ROUTE_YX(ROUTE_YX)) u_route_calc (
    .dest_x  (dest_x),
    .dest_y  (dest_y),
    .router_x(router_x_i),
    .router_y(router_y_i),
    .route   (calc_route)
  );
  // Out-of-range VC ids match no entry, so they read as an inactive, empty slot.
  always_comb begin
    cur_route  = '0;
    cur_active = 1'b0;
    for (int i = 0; i < NUM_VC; i++)
      if (vc == VC_W'(i)) begin
        cur_route  = tbl_route[i];
        cur_active = tbl_active[i];
      end
  end
  assign vc_ok        = int'(vc) < NUM_VC;
  assign is_new       = (ftype == FT_HEAD) || (ftype == FT_HEAD_TAIL);
  assign nxt_route    = !vc_ok ? '0 : is_new ? calc_route : cur_active ? cur_route : '0;
  assign nxt_err      = !vc_ok || ((ftype == FT_HEAD) ? cur_active : (!is_new && !cur_active));
  assign flit_ready_o = !flit_valid_o || flit_ready_i;
  assign accept       = flit_valid_i && flit_ready_o;
  always_ff @(posedge clk or negedge arst)
    if (!arst) begin
      tbl_active <= '0;
      for (int i = 0; i < NUM_VC; i++) tbl_route[i] <= '0;
    end else if (accept && vc_ok) begin
      for (int i = 0; i < NUM_VC; i++)
        if (vc == VC_W'(i)) begin
          if (ftype == FT_HEAD) begin
            tbl_route[i]  <= calc_route;
            tbl_active[i] <= 1'b1;
          end
          if (ftype == FT_TAIL) tbl_active[i] <= 1'b0;
        end
    end
  always_ff @(posedge clk or negedge arst)
    if (!arst) begin
      flit_valid_o <= 1'b0;
      flit_o       <= '0;
      route_o      <= '0;
      vc_o         <= '0;
      route_err_o  <= 1'b0;
    end else if (accept) begin
      flit_valid_o <= 1'b1;
      flit_o       <= flit_i;
      route_o      <= nxt_route;
      vc_o         <= vc;
      route_err_o  <= nxt_err;
    end else if (flit_ready_i) flit_valid_o <= 1'b0;
endmodule

// File: tb/tb_input_router_vc.sv
// tb_input_router_vc: directed plus randomized checks of XY and YX instances against a transfer-level model
module tb_input_router_vc;
  localparam int FW = 34;
  localparam int NV = 3;
  localparam int VW = 2;
  localparam logic [1:0] HD = 2'b00, BD = 2'b01, TL = 2'b10, HT = 2'b11;
  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rx, ry;
  logic [FW-1:0] f_in;
  logic v_in, r_in;
  logic [1:0][FW-1:0] f_o;
  logic [1:0] v_o, rdy_o, err_o;
  logic [1:0][4:0] rt_o;
  logic [1:0][VW-1:0] vc_o;
  int checks = 0;
  int failures = 0;
  bit m_act [2][NV];
  logic [4:0] m_tab [2][NV];
  bit m_v [2];
  logic [FW-1:0] m_f [2];
  logic [4:0] m_r [2];
  int m_vc [2];
  bit m_e [2];
  input_router_vc #(.ROUTE_YX(1'b0)) dut_xy (
    .clk(clk), .arst(arst), .router_x_i(rx), .router_y_i(ry),
    .flit_i(f_in), .flit_valid_i(v_in), .flit_ready_o(rdy_o[0]),
    .flit_o(f_o[0]), .flit_valid_o(v_o[0]), .flit_ready_i(r_in),
    .route_o(rt_o[0]), .vc_o(vc_o[0]), .route_err_o(err_o[0])
  );
  input_router_vc #(.ROUTE_YX(1'b1)) dut_yx (
    .clk(clk), .arst(arst), .router_x_i(rx), .router_y_i(ry),
    .flit_i(f_in), .flit_valid_i(v_in), .flit_ready_o(rdy_o[1]),
    .flit_o(f_o[1]), .flit_valid_o(v_o[1]), .flit_ready_i(r_in),
    .route_o(rt_o[1]), .vc_o(vc_o[1]), .route_err_o(err_o[1])
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask
  // Dimension-ordered route straight from the rules: east/west from X, south/north from Y (Y grows south).
  function automatic logic [4:0] ref_route(input int dx, input int dy, input int px, input int py, input bit yx);
    logic [4:0] xs, ys;
    xs = dx > px ? 5'b10000 : dx < px ? 5'b01000 : 5'b00000;
    ys = dy > py ? 5'b00100 : dy < py ? 5'b00010 : 5'b00000;
    if (yx) return ys != 0 ? ys : xs != 0 ? xs : 5'b00001;
    return xs != 0 ? xs : ys != 0 ? ys : 5'b00001;
  endfunction
  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [1:0] vc, input logic [1:0] x,
                                        input logic [1:0] y);
    logic [FW-1:0] f;
    f = FW'({$urandom(), $urandom()});
    f[FW-1 -: 2] = t;
    f[5:4] = y;
    f[3:2] = x;
    f[1:0] = vc;
    return f;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0;
      m_f[k] = '0;
      m_r[k] = '0;
      m_vc[k] = 0;
      m_e[k] = 0;
      for (int i = 0; i < NV; i++) begin
        m_act[k][i] = 0;
        m_tab[k][i] = '0;
      end
    end
  endtask
  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      bit rdy;
      int t, vc;
      logic [4:0] r;
      bit e;
      rdy = !m_v[k] || r_in;
      t = int'(f_in[FW-1 -: 2]);
      vc = int'(f_in[1:0]);
      if (v_in && rdy) begin
        if (vc >= NV) begin
          r = '0;
          e = 1;
        end else if (t == 0 || t == 3) begin
          r = ref_route(int'(f_in[3:2]), int'(f_in[5:4]), int'(rx), int'(ry), k == 1);
          e = (t == 0) && m_act[k][vc];
          if (t == 0) begin
            m_tab[k][vc] = r;
            m_act[k][vc] = 1;
          end
        end else begin
          e = !m_act[k][vc];
          r = m_act[k][vc] ? m_tab[k][vc] : 5'b0;
          if (t == 2) m_act[k][vc] = 0;
        end
        m_v[k] = 1;
        m_f[k] = f_in;
        m_r[k] = r;
        m_vc[k] = vc;
        m_e[k] = e;
      end else if (r_in) m_v[k] = 0;
    end
  endtask
  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      string s;
      s = k ? "yx" : "xy";
      chk({s, "_ready"}, rdy_o[k], !m_v[k] || r_in);
      chk({s, "_valid"}, v_o[k], m_v[k]);
      chk({s, "_onehot0"}, $onehot0(rt_o[k]), 1);
      if (m_v[k]) begin
        chk({s, "_flit"}, f_o[k], m_f[k]);
        chk({s, "_route"}, rt_o[k], m_r[k]);
        chk({s, "_vc"}, vc_o[k], m_vc[k]);
        chk({s, "_err"}, err_o[k], m_e[k]);
      end
    end
  endtask
  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_valid"}, v_o[k], 0);
      chk({tag, "_flit"}, f_o[k], 0);
      chk({tag, "_route"}, rt_o[k], 0);
      chk({tag, "_vc"}, vc_o[k], 0);
      chk({tag, "_err"}, err_o[k], 0);
    end
  endtask
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_clock();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] t, input logic [1:0] vc, input logic [1:0] x, input logic [1:0] y);
    f_in = mk(t, vc, x, y);
    v_in = 1'b1;
    cycle();
    v_in = 1'b0;
  endtask
  initial begin
    rx = 2'd1;
    ry = 2'd1;
    f_in = '0;
    v_in = 1'b0;
    r_in = 1'b1;
    model_reset();
    #2;
    check_reset_state("por");
    #10 arst = 1'b1;
    @(posedge clk);
    #1;
    send(HD, 2'd0, 2'd2, 2'd0);
    chk("xy_head_east", rt_o[0], 5'b10000);
    chk("xy_head_err", err_o[0], 0);
    send(BD, 2'd0, 2'd0, 2'd0);
    chk("xy_body_east", rt_o[0], 5'b10000);
    send(TL, 2'd0, 2'd0, 2'd0);
    chk("xy_tail_east", rt_o[0], 5'b10000);
    send(HT, 2'd0, 2'd2, 2'd0);
    chk("yx_ht_north", rt_o[1], 5'b00010);
    chk("xy_ht_east", rt_o[0], 5'b10000);
    send(BD, 2'd0, 2'd0, 2'd0);
    chk("body_after_ht_route", rt_o[1], 5'b00000);
    chk("body_after_ht_err", err_o[1], 1);
    send(HD, 2'd0, 2'd0, 2'd1);
    chk("il_head_west", rt_o[0], 5'b01000);
    send(HD, 2'd1, 2'd1, 2'd1);
    chk("il_head_local", rt_o[0], 5'b00001);
    for (int i = 0; i < 4; i++) begin
      send(BD, 2'(i % 2), 2'(i), 2'(3 - i));
      chk("il_body", rt_o[0], (i % 2) ? 5'b00001 : 5'b01000);
    end
    send(HD, 2'd2, 2'd3, 2'd1);
    chk("ovr_first_east", rt_o[0], 5'b10000);
    send(HD, 2'd2, 2'd1, 2'd3);
    chk("ovr_second_south", rt_o[0], 5'b00100);
    chk("ovr_second_err", err_o[0], 1);
    send(BD, 2'd2, 2'd0, 2'd0);
    chk("ovr_body_south", rt_o[0], 5'b00100);
    chk("ovr_body_err", err_o[0], 0);
    f_in = mk(TL, 2'd2, 2'd0, 2'd0);
    v_in = 1'b1;
    r_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready_low", rdy_o[0], 0);
    end
    r_in = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) send(BD, 2'd2, 2'd0, 2'd0);
    chk("bp_body_after_tail_err", err_o[0], 1);
    send(HD, 2'd3, 2'd2, 2'd2);
    chk("bad_vc_route", rt_o[0], 5'b00000);
    chk("bad_vc_err", err_o[0], 1);
    send(HD, 2'd0, 2'd2, 2'd1);
    send(BD, 2'd0, 2'd0, 2'd0);
    arst = 1'b0;
    #1;
    check_reset_state("mid_rst");
    model_reset();
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    #1;
    send(BD, 2'd0, 2'd0, 2'd0);
    chk("post_rst_body_route", rt_o[0], 5'b00000);
    chk("post_rst_body_err", err_o[0], 1);
    for (int p = 0; p < 4; p++) begin
      rx = 2'($urandom_range(0, 3));
      ry = 2'($urandom_range(0, 3));
      for (int i = 0; i < 600; i++) begin
        f_in = mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)));
        v_in = $urandom_range(0, 3) != 0;
        r_in = $urandom_range(0, 3) != 0;
        cycle();
      end
    end
    v_in = 1'b0;
    r_in = 1'b1;
    cycle();
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
